// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-driven bus master: protocol byte values,
// the controller state encoding and a small state-classification helper.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_AHI,
        S_ALO,
        S_LEN,
        S_GRANT,
        S_WDATA,
        S_BUS,
        S_CAPT,
        S_TXW,
        S_NEXT
    } state_t;

    // States in which an incoming byte is consumed rather than dropped.
    function automatic logic accepts_rx(input state_t s);
        return (s == S_IDLE) || (s == S_AHI) || (s == S_ALO) ||
               (s == S_LEN)  || (s == S_WDATA);
    endfunction

endpackage

// File: rtl/uart_bus_master_rx_gap_timer.sv
// rx_gap_timer: idle-gap watchdog between command bytes. Down-counter that
// reloads on every received byte (or while disabled) and flags expiry when
// it reaches zero. Only instantiated when UART_BUS_MASTER_TIMEOUT_EN is set.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on activity or when not armed, otherwise count down to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= CNT_LOAD;
        end else if (i_clear || !i_enable) begin
            r_cnt <= CNT_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_expired = i_enable && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: byte-stream command parser that acts as a second bus
// initiator. 'W' ahi alo len data... writes and replies ACK; 'R' ahi alo len
// reads and returns len bytes; anything else in IDLE gets NAK.
// Optional: UART_BUS_MASTER_TIMEOUT_EN adds an inter-byte gap timeout that
// aborts the command with NAK.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command byte
// AHI/ALO | capturing address high / low byte
// LEN     | capturing length byte (0 = 256)
// GRANT   | bus requested, waiting for grant
// WDATA   | waiting for the next write data byte
// BUS     | o_cs high, waiting for ack
// CAPT    | read data registered into the reply byte
// TXW     | waiting for transmitter idle, then strobe
// NEXT    | count down / address up, pick next step
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_dat,
    output logic        o_tx_stb,
    input  logic        i_tx_busy,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    input  logic [7:0]  i_dat,
    output logic        o_cs,
    output logic        o_we,
    input  logic        i_ack,
    output logic        o_overrun
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_write;
    logic [15:0] r_addr;
    logic [8:0]  r_cnt;
    logic [8:0]  w_cnt_dec;
    logic [7:0]  r_wdat;
    logic        r_dat_ok;
    logic [7:0]  r_tx_dat;
    logic        r_tx_stb;
    logic        r_tx_last;
    logic        r_cs;
    logic        r_we;
    logic        r_bus_req;
    logic        r_overrun;
    logic        w_is_cmd;
    logic        w_timeout;

    assign w_cnt_dec = r_cnt - 9'd1;
    assign w_is_cmd  = (i_rx_dat == CMD_READ) || (i_rx_dat == CMD_WRITE);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    logic w_timer_en;

    assign w_timer_en = (r_state == S_AHI) || (r_state == S_ALO) ||
                        (r_state == S_LEN) || (r_state == S_WDATA);

    rx_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_gap_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_rx_valid),
        .i_enable  (w_timer_en),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a gap timeout overrides everything with a NAK reply.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_rx_valid) w_state_nxt = w_is_cmd ? S_AHI : S_TXW;
            S_AHI:   if (i_rx_valid) w_state_nxt = S_ALO;
            S_ALO:   if (i_rx_valid) w_state_nxt = S_LEN;
            S_LEN:   if (i_rx_valid) w_state_nxt = S_GRANT;
            S_GRANT: begin
                if (i_bus_gnt) begin
                    w_state_nxt = (r_is_write && !r_dat_ok) ? S_WDATA : S_BUS;
                end
            end
            S_WDATA: if (i_rx_valid) w_state_nxt = i_bus_gnt ? S_BUS : S_GRANT;
            S_BUS:   if (i_ack) w_state_nxt = r_is_write ? S_NEXT : S_CAPT;
            S_CAPT:  w_state_nxt = S_TXW;
            S_TXW:   if (!i_tx_busy) w_state_nxt = r_tx_last ? S_IDLE : S_NEXT;
            S_NEXT: begin
                if (w_cnt_dec != 9'd0) begin
                    if (r_is_write)     w_state_nxt = S_WDATA;
                    else if (i_bus_gnt) w_state_nxt = S_BUS;
                    else                w_state_nxt = S_GRANT;
                end else begin
                    w_state_nxt = r_is_write ? S_TXW : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_TXW;
        end
    end

    // Datapath and registered outputs, decoded from the upcoming state so
    // that bus and strobe outputs come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_is_write <= 1'b0;
            r_addr     <= 16'h0000;
            r_cnt      <= 9'd0;
            r_wdat     <= 8'h00;
            r_dat_ok   <= 1'b0;
            r_tx_dat   <= 8'h00;
            r_tx_stb   <= 1'b0;
            r_tx_last  <= 1'b0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_bus_req  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_cs     <= (w_state_nxt == S_BUS);
            r_we     <= (w_state_nxt == S_BUS) && r_is_write;
            r_tx_stb <= (r_state == S_TXW) && !i_tx_busy;

            if (w_timeout || (w_state_nxt == S_IDLE)) begin
                r_bus_req <= 1'b0;
            end else if (w_state_nxt == S_GRANT) begin
                r_bus_req <= 1'b1;
            end

            if (i_rx_valid && !accepts_rx(r_state)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        if (w_is_cmd) begin
                            r_is_write <= (i_rx_dat == CMD_WRITE);
                            r_overrun  <= 1'b0;
                        end else begin
                            r_tx_dat  <= RSP_NAK;
                            r_tx_last <= 1'b1;
                        end
                    end
                end
                S_AHI: if (i_rx_valid) r_addr[15:8] <= i_rx_dat;
                S_ALO: if (i_rx_valid) r_addr[7:0]  <= i_rx_dat;
                S_LEN: begin
                    if (i_rx_valid) begin
                        r_cnt    <= (i_rx_dat == 8'h00) ? 9'd256 : {1'b0, i_rx_dat};
                        r_dat_ok <= 1'b0;
                    end
                end
                S_WDATA: begin
                    if (i_rx_valid) begin
                        r_wdat   <= i_rx_dat;
                        r_dat_ok <= 1'b1;
                    end
                end
                S_CAPT: begin
                    r_tx_dat  <= i_dat;
                    r_tx_last <= 1'b0;
                end
                S_NEXT: begin
                    r_cnt    <= w_cnt_dec;
                    r_addr   <= r_addr + 16'd1;
                    r_dat_ok <= 1'b0;
                    if ((w_cnt_dec == 9'd0) && r_is_write) begin
                        r_tx_dat  <= RSP_ACK;
                        r_tx_last <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_timeout) begin
                r_tx_dat  <= RSP_NAK;
                r_tx_last <= 1'b1;
            end
        end
    end

    assign o_tx_dat  = r_tx_dat;
    assign o_tx_stb  = r_tx_stb;
    assign o_bus_req = r_bus_req;
    assign o_addr    = r_addr;
    assign o_dat     = r_wdat;
    assign o_cs      = r_cs;
    assign o_we      = r_we;
    assign o_overrun = r_overrun;

endmodule
